// File: rtl/sha1_wb_stream_if.sv
// Wishbone slave bus bundle for the SHA-1 streaming front end.
// The bench drives the master side; the hashing block sits on the slave side.
interface sha1_wb_stream_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/sha1_wb_stream.sv
// Wishbone-fed SHA-1 block sequencer: buffers message words in a FIFO, feeds
// 512-bit blocks to an external compression core and chains the digest.
module sha1_wb_stream #(
    parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
    parameter int          FIFO_DEPTH   = 32,
    parameter int          LW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   wb_clk_i,
    input  logic                   reset,
    sha1_wb_stream_if.slave        wbs,
    output logic                   done,
    output logic                   irq,
    output logic                   core_start,
    output logic [511:0]           core_block,
    output logic [159:0]           core_h_in,
    input  logic                   core_done,
    input  logic [159:0]           core_digest
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    typedef enum logic [2:0] {IDLE, FILL, RUN, WAIT, NEXT, FIN} state_t;
    state_t state, next_state;

    logic [31:0]   offset;
    logic [3:0]    reg_idx;
    logic          in_range, bus_req, wr_ok;
    logic          ctrl_wr, status_wr, msg_wr, soft_rst_cmd, start_cmd;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          fifo_full, fifo_empty, push, pop;
    logic          done_r, ovf, irq_en;
    logic [7:0]    remaining;
    logic [3:0]    word_cnt;
    logic [159:0]  h_reg;
    logic [31:0]   rd_data, status_word;

    // Addresses below the base wrap to huge offsets and fall out of range.
    assign offset    = wbs.wbs_adr_i - BASE_ADDRESS;
    assign reg_idx   = offset[5:2];
    assign in_range  = (offset < 32'h24) && (offset[1:0] == 2'b00);
    assign bus_req   = wbs.wbs_stb_i & wbs.wbs_cyc_i & in_range & ~wbs.wbs_ack_o;
    assign wr_ok     = bus_req & wbs.wbs_we_i & (wbs.wbs_sel_i == 4'hF);
    assign ctrl_wr   = wr_ok & (reg_idx == 4'd1);
    assign status_wr = wr_ok & (reg_idx == 4'd2);
    assign msg_wr    = wr_ok & (reg_idx == 4'd3);

    assign soft_rst_cmd = ctrl_wr & wbs.wbs_dat_i[1];
    assign start_cmd    = ctrl_wr & wbs.wbs_dat_i[0] & ~wbs.wbs_dat_i[1] & (state == IDLE);

    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign push       = msg_wr & ~fifo_full;
    assign pop        = (state == FILL) & ~fifo_empty;

    assign core_h_in = h_reg;
    assign done      = done_r;
    assign irq       = done_r & irq_en;

    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        core_start = 1'b0;
        case (state)
            IDLE: if (start_cmd) next_state = FILL;
            FILL: if (pop && word_cnt == 4'd15) next_state = RUN;
            RUN: begin
                core_start = 1'b1;
                next_state = WAIT;
            end
            WAIT: if (core_done) next_state = NEXT;
            NEXT: next_state = (remaining != 8'd0) ? FILL : FIN;
            FIN:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (soft_rst_cmd) next_state = IDLE;
    end

    // Storage only; pointers and level carry all the reset semantics.
    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem[wr_ptr] <= wbs.wbs_dat_i;
    end

    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            done_r     <= 1'b0;
            ovf        <= 1'b0;
            irq_en     <= 1'b0;
            remaining  <= 8'd0;
            word_cnt   <= 4'd0;
            core_block <= '0;
            h_reg      <= IV;
        end else if (soft_rst_cmd) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            done_r     <= 1'b0;
            ovf        <= 1'b0;
            irq_en     <= 1'b0;
            remaining  <= 8'd0;
            word_cnt   <= 4'd0;
            core_block <= '0;
            h_reg      <= IV;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                core_block[{~word_cnt, 5'd0} +: 32] <= fifo_mem[rd_ptr];
                word_cnt <= word_cnt + 4'd1;
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            if (msg_wr && fifo_full)                 ovf <= 1'b1;
            else if (status_wr && wbs.wbs_dat_i[2])  ovf <= 1'b0;

            if (ctrl_wr) irq_en <= wbs.wbs_dat_i[2];

            if (start_cmd) begin
                remaining <= (wbs.wbs_dat_i[15:8] == 8'd0) ? 8'd1 : wbs.wbs_dat_i[15:8];
                h_reg     <= IV;
                done_r    <= 1'b0;
                word_cnt  <= 4'd0;
            end else if (status_wr && wbs.wbs_dat_i[1]) begin
                done_r <= 1'b0;
            end

            if (state == WAIT && core_done) begin
                h_reg     <= core_digest;
                remaining <= remaining - 8'd1;
            end
            if (state == FIN) done_r <= 1'b1;
        end
    end

    always_comb begin
        status_word             = '0;
        status_word[0]          = (state != IDLE);
        status_word[1]          = done_r;
        status_word[2]          = ovf;
        status_word[3]          = irq_en;
        status_word[15:8]       = remaining;
        status_word[16 +: LW]   = level;
    end

    // Digest registers hide the chaining value until the final block is done.
    always_comb begin
        rd_data = 32'h0;
        case (reg_idx)
            4'd0: rd_data = 32'h53484132;
            4'd2: rd_data = status_word;
            4'd3: rd_data = 32'h0fffffea;
            4'd4: rd_data = done_r ? h_reg[159:128] : 32'hfffffff0;
            4'd5: rd_data = done_r ? h_reg[127:96]  : 32'hfffffff0;
            4'd6: rd_data = done_r ? h_reg[95:64]   : 32'hfffffff0;
            4'd7: rd_data = done_r ? h_reg[63:32]   : 32'hfffffff0;
            4'd8: rd_data = done_r ? h_reg[31:0]    : 32'hfffffff0;
            default: rd_data = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= 32'h0;
        end else begin
            wbs.wbs_ack_o <= bus_req;
            if (bus_req) wbs.wbs_dat_o <= wbs.wbs_we_i ? 32'h00000001 : rd_data;
            else         wbs.wbs_dat_o <= 32'h0;
        end
    end
endmodule

// File: tb/tb_sha1_wb_stream.sv
// Bench for sha1_wb_stream: transaction-level model of the register file and
// FIFO plus a behavioural SHA-1 core answering core_start requests.
module tb_sha1_wb_stream;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [31:0]  BASE = 32'h30000024;
    localparam logic [159:0] IV   = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    logic         wb_clk_i = 1'b0;
    logic         reset = 1'b1;
    logic         done, irq, core_start;
    logic         core_done = 1'b0;
    logic [511:0] core_block;
    logic [159:0] core_h_in;
    logic [159:0] core_digest = '0;

    sha1_wb_stream_if wbs ();

    sha1_wb_stream #(.BASE_ADDRESS(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i(wb_clk_i), .reset(reset), .wbs(wbs), .done(done), .irq(irq),
        .core_start(core_start), .core_block(core_block), .core_h_in(core_h_in),
        .core_done(core_done), .core_digest(core_digest)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int unsigned  m_q[$];
    bit           m_done, m_ovf, m_irq_en, m_busy;
    int           m_rem;
    logic [159:0] m_h;
    logic [511:0] m_block;
    int           start_count = 0;
    bit           exp_pending = 0;
    bit           watch_no_ack = 0;
    logic [31:0]  exp_dat;
    int           tests_run = 0;
    int           tests_failed = 0;

    task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        {a, b, c, d, e} = h;
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_done = 0; m_ovf = 0; m_irq_en = 0; m_busy = 0; m_rem = 0; m_h = IV;
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s = '0;
        s[0] = m_busy; s[1] = m_done; s[2] = m_ovf; s[3] = m_irq_en;
        s[15:8] = m_rem[7:0];
        s[16 +: LW] = LW'(m_q.size());
        return s;
    endfunction

    function automatic void model_write(input logic [31:0] off, input logic [31:0] d);
        if (off == 32'h4) begin
            if (d[1]) model_reset();
            else begin
                m_irq_en = d[2];
                if (d[0] && !m_busy) begin
                    m_rem = (d[15:8] == 0) ? 1 : int'(d[15:8]);
                    m_h = IV; m_done = 0; m_busy = 1;
                end
            end
        end else if (off == 32'h8) begin
            if (d[1]) m_done = 0;
            if (d[2]) m_ovf = 0;
        end else if (off == 32'hC) begin
            if (m_q.size() == DEPTH) m_ovf = 1;
            else m_q.push_back(d);
        end
    endfunction

    // Single compare process: bus acks/read data and every core_start request.
    always @(posedge wb_clk_i) begin : monitor
        logic [511:0] blk;
        #2;
        if (!reset) begin
            if (exp_pending) begin
                check_output("ack_latency", wbs.wbs_ack_o, 1'b1);
                if (wbs.wbs_ack_o) check_output("read_data", wbs.wbs_dat_o, exp_dat);
                exp_pending = 0;
            end else if (watch_no_ack || wbs.wbs_ack_o) begin
                check_output("no_ack", wbs.wbs_ack_o, 1'b0);
            end
            if (core_start) begin
                check_output("start_expected", m_busy && m_q.size() >= 16, 1'b1);
                if (m_q.size() >= 16) begin
                    for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = m_q.pop_front();
                    m_block = blk;
                    check_output("core_block", core_block, blk);
                    check_output("core_h_in", core_h_in, m_h);
                end
                start_count++;
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] adr, input bit we, input logic [31:0] d,
                                  input logic [31:0] expd, input bit expect_ack);
        @(negedge wb_clk_i);
        wbs.wbs_stb_i = 1; wbs.wbs_cyc_i = 1; wbs.wbs_we_i = we;
        wbs.wbs_sel_i = 4'hF; wbs.wbs_adr_i = adr; wbs.wbs_dat_i = d;
        if (expect_ack) begin exp_dat = expd; exp_pending = 1; end
        else watch_no_ack = 1;
        @(negedge wb_clk_i);
        wbs.wbs_stb_i = 0; wbs.wbs_cyc_i = 0; wbs.wbs_we_i = 0;
        if (!expect_ack) begin
            repeat (2) @(negedge wb_clk_i);
            watch_no_ack = 0;
        end
    endtask

    task automatic wb_read(input logic [31:0] off, input logic [31:0] expd);
        apply_stimulus(BASE + off, 1'b0, 32'h0, expd, 1'b1);
    endtask

    task automatic wb_write(input logic [31:0] off, input logic [31:0] d);
        model_write(off, d);
        apply_stimulus(BASE + off, 1'b1, d, 32'h1, 1'b1);
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) wb_write(32'hC, $urandom);
    endtask

    task automatic read_digests();
        for (int i = 0; i < 5; i++)
            wb_read(32'h10 + 4*i, m_done ? m_h[159-32*i -: 32] : 32'hfffffff0);
    endtask

    task automatic wait_start(input int prev);
        int n = 0;
        while (start_count == prev && n < 300) begin
            @(negedge wb_clk_i);
            n++;
        end
        check_output("core_start_seen", start_count != prev, 1'b1);
    endtask

    task automatic core_respond(input int delay, input bit update);
        logic [159:0] dg;
        repeat (delay) @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        dg = update ? sha1_compress(m_h, m_block) : {$urandom, $urandom, $urandom, $urandom, $urandom};
        core_digest = dg;
        core_done = 1;
        if (update) begin
            m_h = dg;
            m_rem--;
            if (m_rem == 0) begin m_busy = 0; m_done = 1; end
        end
        @(negedge wb_clk_i);
        core_done = 0;
        repeat (4) @(negedge wb_clk_i);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_ack", wbs.wbs_ack_o, 1'b0);
        check_output("rst_dat", wbs.wbs_dat_o, 32'h0);
        check_output("rst_core_start", core_start, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_irq", irq, 1'b0);
        check_output("rst_h_in", core_h_in, IV);
    endtask

    initial begin
        #500000;
        tests_failed++;
        $display("[TB] FAIL global_timeout: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        int prev, nb, ie;
        wbs.wbs_stb_i = 0; wbs.wbs_cyc_i = 0; wbs.wbs_we_i = 0;
        wbs.wbs_sel_i = 0; wbs.wbs_adr_i = 0; wbs.wbs_dat_i = 0;
        model_reset();
        repeat (2) @(negedge wb_clk_i);
        check_reset_outputs();
        reset = 0;

        // Register map basics and ack behaviour.
        wb_read(32'h0, 32'h53484132);
        apply_stimulus(BASE + 32'h24, 1'b0, 32'h0, 32'h0, 1'b0);
        apply_stimulus(BASE - 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
        wb_read(32'hC, 32'h0fffffea);
        wb_read(32'h8, model_status());
        wb_read(32'h10, 32'hfffffff0);
        @(negedge wb_clk_i);
        wbs.wbs_stb_i = 1; wbs.wbs_cyc_i = 1; wbs.wbs_we_i = 0; wbs.wbs_adr_i = BASE;
        exp_dat = 32'h53484132; exp_pending = 1;
        @(negedge wb_clk_i);
        watch_no_ack = 1;
        @(negedge wb_clk_i);
        wbs.wbs_stb_i = 0; wbs.wbs_cyc_i = 0;
        @(negedge wb_clk_i);
        watch_no_ack = 0;

        // Padded "abc" pins the model against the published digest.
        wb_write(32'hC, 32'h61626380);
        for (int i = 0; i < 14; i++) wb_write(32'hC, 32'h0);
        wb_write(32'hC, 32'h00000018);
        prev = start_count;
        wb_write(32'h4, 32'h0105);
        wait_start(prev);
        core_respond(3, 1);
        check_output("abc_irq", irq, 1'b1);
        check_output("abc_done", done, 1'b1);
        wb_read(32'h10, 32'ha9993e36);
        wb_read(32'h14, 32'h4706816a);
        wb_read(32'h18, 32'hba3e2571);
        wb_read(32'h1C, 32'h7850c26c);
        wb_read(32'h20, 32'h9cd0d89d);
        wb_read(32'h8, model_status());
        wb_write(32'h8, 32'h2);
        check_output("w1c_done_irq", irq, 1'b0);

        // Overflow on the 17th push while idle.
        push_words(17);
        wb_read(32'h8, model_status());
        check_output("ovf_status_lit", model_status(), 32'h0010000C);
        wb_write(32'h8, 32'h4);
        wb_read(32'h8, model_status());
        wb_write(32'h4, 32'h2);
        wb_read(32'h8, model_status());

        // Two-block chain, start ignored while busy.
        push_words(16);
        prev = start_count;
        wb_write(32'h4, 32'h0201);
        wait_start(prev);
        wb_read(32'h8, model_status());
        wb_write(32'h4, 32'h0305);
        wb_read(32'h8, model_status());
        core_respond(2, 1);
        wb_read(32'h8, model_status());
        check_output("rem_between_blocks", m_rem, 1);
        prev = start_count;
        push_words(16);
        wait_start(prev);
        core_respond(1, 1);
        read_digests();
        wb_read(32'h8, model_status());
        wb_write(32'h8, 32'h2);

        // Pushes overlapping FILL pops; nblocks=0 means one block.
        push_words(8);
        prev = start_count;
        wb_write(32'h4, 32'h0001);
        push_words(8);
        wait_start(prev);
        wb_read(32'h8, model_status());
        core_respond(0, 1);
        read_digests();

        // Soft reset during WAIT, then a stale core_done.
        push_words(16);
        prev = start_count;
        wb_write(32'h4, 32'h0001);
        wait_start(prev);
        wb_write(32'h4, 32'h0003);
        wb_read(32'h8, model_status());
        core_respond(0, 0);
        wb_read(32'h8, model_status());
        wb_read(32'h10, 32'hfffffff0);

        // Hard reset during WAIT.
        push_words(16);
        prev = start_count;
        wb_write(32'h4, 32'h0001);
        wait_start(prev);
        @(negedge wb_clk_i);
        reset = 1;
        #1;
        check_reset_outputs();
        @(negedge wb_clk_i);
        reset = 0;
        model_reset();
        core_respond(0, 0);
        wb_read(32'h8, model_status());

        // Randomized multi-block runs.
        for (int r = 0; r < 4; r++) begin
            nb = $urandom_range(1, 3);
            ie = $urandom_range(0, 1);
            push_words(16);
            prev = start_count;
            wb_write(32'h4, (nb << 8) | (ie << 2) | 1);
            for (int b = 0; b < nb; b++) begin
                wait_start(prev);
                prev = start_count;
                core_respond($urandom_range(0, 5), 1);
                if (b < nb - 1) push_words(16);
            end
            check_output("rand_irq", irq, m_done & m_irq_en);
            wb_read(32'h8, model_status());
            read_digests();
            wb_write(32'h8, 32'h2);
            check_output("rand_done_clr", done, 1'b0);
        end

        repeat (2) @(negedge wb_clk_i);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
